// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for the unified
// byte-addressed memory. Loads take one READ cycle; word stores take one
// WRITE cycle; byte/halfword stores do READ then WRITE (read-modify-write)
// because the memory port only writes whole 32-bit words.
//
// Build option: define ALIGN_CHECK_EN to reject misaligned halfword/word
// accesses with a fault. Without it, misaligned accesses go to the memory at
// the byte address given.
//
// Handshake: req_ready is high only in IDLE. A request is taken on the rising
// edge where req_valid && req_ready; all req_* fields are latched on that edge
// and ignored at every other time. resp_valid is a single-cycle pulse with no
// backpressure; resp_rdata/resp_fault are meaningful only while it is high and
// read back as zero otherwise.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 800,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Highest address whose 4-byte window still fits in the memory.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state_q;
  state_t            state_d;

  // Request fields latched at accept.
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              write_q;
  logic [31:0]       wdata_q;

  // Word read in READ, used as the background for sub-word stores.
  logic [31:0]       cap_q;

  // Response and memory-address registers.
  logic [31:0]       resp_rdata_q;
  logic              resp_fault_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              accept;
  logic              req_misalign;
  logic              req_fault;
  logic [31:0]       load_ext;
  logic [31:0]       merged_word;

  assign accept = req_valid && (state_q == IDLE);

  // Alignment rule for the incoming request; only active in the checked build.
  always_comb begin
    req_misalign = 1'b0;
`ifdef ALIGN_CHECK_EN
    if (req_size == SIZE_HALF && req_addr[0] != 1'b0) begin
      req_misalign = 1'b1;
    end
    if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) begin
      req_misalign = 1'b1;
    end
`endif
  end

  // Decide at accept whether the request is rejected without touching memory.
  always_comb begin
    req_fault = 1'b0;
    if (req_size == SIZE_RSVD) begin
      req_fault = 1'b1;
    end
    if (req_addr > MAX_ADDR) begin
      req_fault = 1'b1;
    end
    if (req_misalign) begin
      req_fault = 1'b1;
    end
  end

  // Extract and extend the load result from the word presented in READ.
  always_comb begin
    load_ext = 32'd0;
    case (size_q)
      SIZE_BYTE: load_ext = {{24{signed_q & mem_read_data[7]}},  mem_read_data[7:0]};
      SIZE_HALF: load_ext = {{16{signed_q & mem_read_data[15]}}, mem_read_data[15:0]};
      default:   load_ext = mem_read_data;
    endcase
  end

  // Build the word to store: sub-word stores overlay the captured word.
  always_comb begin
    merged_word = wdata_q;
    case (size_q)
      SIZE_BYTE: merged_word = {cap_q[31:8],  wdata_q[7:0]};
      SIZE_HALF: merged_word = {cap_q[31:16], wdata_q[15:0]};
      default:   merged_word = wdata_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_fault) begin
            state_d = RESP;
          end else if (req_write && req_size == SIZE_WORD) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch request fields at accept; memory address only moves for real accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= 32'd0;
      mem_addr_q <= '0;
    end else if (accept) begin
      addr_q   <= req_addr;
      size_q   <= req_size;
      signed_q <= req_signed;
      write_q  <= req_write;
      wdata_q  <= req_wdata;
      if (!req_fault) begin
        mem_addr_q <= req_addr;
      end
    end
  end

  // Capture the memory word at the end of the READ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= 32'd0;
    end else if (state_q == READ) begin
      cap_q <= mem_read_data;
    end
  end

  // Response payload: loaded for exactly the RESP cycle, zero at all other times.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
    end else begin
      resp_fault_q <= accept && req_fault;
      if (state_q == READ && !write_q) begin
        resp_rdata_q <= load_ext;
      end else begin
        resp_rdata_q <= 32'd0;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

  // Memory port: driven only from registered state and latched fields.
  // mem_addr_q was loaded with the accepted address, so it equals addr_q
  // during READ/WRITE and holds its last value elsewhere.
  assign mem_address    = mem_addr_q;
  assign mem_write_en   = (state_q == WRITE) && !reset;
  assign mem_write_data = (state_q == WRITE) ? merged_word : 32'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array memory model.
module tb_mem_access_ctrl;

  localparam int MEM_BYTES = 800;
  localparam int ADDR_W    = 32;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_en;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  logic [7:0] mem [MEM_BYTES];

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational little-endian read, word write on the clock edge.
  always_comb begin
    mem_read_data = 32'd0;
    if (mem_address <= 32'(MEM_BYTES - 4)) begin
      mem_read_data = {mem[int'(mem_address) + 3], mem[int'(mem_address) + 2],
                       mem[int'(mem_address) + 1], mem[int'(mem_address)]};
    end
  end

  always @(posedge clk) begin
    if (mem_write_en && mem_address <= 32'(MEM_BYTES - 4)) begin
      mem[int'(mem_address)]     <= mem_write_data[7:0];
      mem[int'(mem_address) + 1] <= mem_write_data[15:8];
      mem[int'(mem_address) + 2] <= mem_write_data[23:16];
      mem[int'(mem_address) + 3] <= mem_write_data[31:24];
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: drive, accept, watch until resp_valid, then check
  // latency (negedges after the accept edge), payload, write strobes and the
  // return of the response fields to zero.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_flt,
                        input int exp_strobes, input logic [31:0] exp_wword);
    int          lat;
    int          strobes;
    logic [31:0] wword;
    logic [31:0] rd;
    logic        flt;
    lat = 0; strobes = 0; wword = 32'd0; rd = 32'd0; flt = 1'b0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 32'($urandom_range(0, 1000));
    req_wdata  = $urandom;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
      if (mem_write_en) begin
        strobes++;
        wword = mem_write_data;
      end
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        flt = resp_fault;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"},   rd, exp_rd);
    check({tag, ".fault"},   32'(flt), 32'(exp_flt));
    check({tag, ".strobes"}, 32'(strobes), 32'(exp_strobes));
    if (exp_strobes > 0) check({tag, ".wword"}, wword, exp_wword);
    @(negedge clk);
    check({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".post_rdata"}, resp_rdata, 32'd0);
    check({tag, ".post_fault"}, 32'(resp_fault), 32'd0);
    check({tag, ".post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i);
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.valid", 32'(resp_valid), 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.fault", 32'(resp_fault), 32'd0);
    check("rst.maddr", mem_address, 32'd0);
    check("rst.wen",   32'(mem_write_en), 32'd0);
    check("rst.wdata", mem_write_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word store / load
    do_req("sw40",  1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 2, 32'h0, 0, 1, 32'hDEADBEEF);
    check("sw40.mem", mem_word(32'h40), 32'hDEADBEEF);
    do_req("lw40",  0, 2'b10, 0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 0, 0, 32'h0);

    // Byte store (read-modify-write) and byte loads
    do_req("sb40",  1, 2'b00, 0, 32'h40, 32'h000000A5, 3, 32'h0, 0, 1, 32'hDEADBEA5);
    do_req("lbs40", 0, 2'b00, 1, 32'h40, 32'h0, 2, 32'hFFFFFFA5, 0, 0, 32'h0);
    do_req("lbu40", 0, 2'b00, 0, 32'h40, 32'h0, 2, 32'h000000A5, 0, 0, 32'h0);

    // Halfword stores and loads; bytes 0x44/0x45 keep their initial pattern
    do_req("sh42a", 1, 2'b01, 0, 32'h42, 32'h00001234, 3, 32'h0, 0, 1, 32'h45441234);
    do_req("lhs42a",0, 2'b01, 1, 32'h42, 32'h0, 2, 32'h00001234, 0, 0, 32'h0);
    do_req("sh42b", 1, 2'b01, 0, 32'h42, 32'h0000DEAD, 3, 32'h0, 0, 1, 32'h4544DEAD);
    do_req("lhs42b",0, 2'b01, 1, 32'h42, 32'h0, 2, 32'hFFFFDEAD, 0, 0, 32'h0);
    do_req("lhu42b",0, 2'b01, 0, 32'h42, 32'h0, 2, 32'h0000DEAD, 0, 0, 32'h0);

    // Range boundary and reserved size
    do_req("lw796", 0, 2'b10, 0, 32'd796, 32'h0, 2, 32'h1F1E1D1C, 0, 0, 32'h0);
    do_req("lw797", 0, 2'b10, 0, 32'd797, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    do_req("sw797", 1, 2'b10, 0, 32'd797, 32'h11223344, 1, 32'h0, 1, 0, 32'h0);
    do_req("lrsvd", 0, 2'b11, 0, 32'h40, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    do_req("srsvd", 1, 2'b11, 0, 32'h40, 32'hCAFEF00D, 1, 32'h0, 1, 0, 32'h0);
    do_req("lwhuge",0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    check("flt.mem40", mem_word(32'h40), 32'hDEADBEA5);

    // Misaligned word load
`ifdef ALIGN_CHECK_EN
    do_req("lw41",  0, 2'b10, 0, 32'h41, 32'h0, 1, 32'h0, 1, 0, 32'h0);
`else
    do_req("lw41",  0, 2'b10, 0, 32'h41, 32'h0, 2, 32'h44DEADBE, 0, 0, 32'h0);
`endif

    // Reset during the WRITE cycle of a byte store
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rstw.in_write_wen_pre", 32'(mem_write_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstw.wen",   32'(mem_write_en), 32'd0);
    check("rstw.valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rstw.ready", 32'(req_ready), 32'd1);
    check("rstw.valid_after", 32'(resp_valid), 32'd0);
    check("rstw.mem40", mem_word(32'h40), 32'hDEADBEA5);
    repeat (3) begin
      @(negedge clk);
      check("rstw.no_resp", 32'(resp_valid), 32'd0);
    end
    do_req("lw40r", 0, 2'b10, 0, 32'h40, 32'h0, 2, 32'hDEADBEA5, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
